// File: rtl/chip_checker_pkg.sv
// Shared definitions for the 74xx socket checker: part codes, sequencer states,
// ROM entry layout and per-part pin masks / vector counts.
package chip_checker_pkg;

   typedef enum logic [3:0] {
      NONE  = 4'd0,
      C7400 = 4'd1,
      C7402 = 4'd2,
      C7404 = 4'd3,
      C7408 = 4'd4
   } chip_code_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      APPLY  = 3'd2,
      SETTLE = 3'd3,
      CHECK  = 3'd4,
      FINISH = 3'd5
   } state_e;

   localparam int NUM_PINS    = 14;
   localparam int MAX_VECTORS = 16;
   localparam int IDX_W       = $clog2(MAX_VECTORS);

   // Pin 7 (GND) and pin 14 (VCC) must never be driven.
   localparam logic [NUM_PINS-1:0] PWR_PINS = 14'h2040;

   typedef struct packed {
      logic [NUM_PINS-1:0] drive;
      logic [NUM_PINS-1:0] expected;
   } vec_entry_t;

   function automatic logic [NUM_PINS-1:0] oe_mask(input logic [3:0] chip);
      case (chip)
         C7400, C7408: oe_mask = 14'h1B1B;
         C7402:        oe_mask = 14'h0DB6;
         C7404:        oe_mask = 14'h1515;
         default:      oe_mask = '0;
      endcase
   endfunction

   function automatic logic [NUM_PINS-1:0] out_mask(input logic [3:0] chip);
      case (chip)
         C7400, C7408: out_mask = 14'h04A4;
         C7402:        out_mask = 14'h1209;
         C7404:        out_mask = 14'h0AAA;
         default:      out_mask = '0;
      endcase
   endfunction

   function automatic logic [IDX_W:0] vec_count(input logic [3:0] chip);
      case (chip)
         C7400, C7402, C7408: vec_count = 5'd4;
         C7404:               vec_count = 5'd2;
         default:             vec_count = 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/chip_vector_rom.sv
// Stimulus/expect vector table for all supported parts, addressed by
// {chip, index}; one-cycle registered read.
module chip_vector_rom
   import chip_checker_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic [3:0]       chip,
   input  logic [IDX_W-1:0] index,
   output vec_entry_t       data
);

   vec_entry_t entry;

   // Each gate gets A,B = 00, 01, 10, 11 in turn; the inverter gets 0 then 1.
   always_comb begin
      entry = '0;
      case ({chip, index})
         8'h10: entry = {14'h0000, 14'h04A4};
         8'h11: entry = {14'h1212, 14'h04A4};
         8'h12: entry = {14'h0909, 14'h04A4};
         8'h13: entry = {14'h1B1B, 14'h0000};
         8'h20: entry = {14'h0000, 14'h1209};
         8'h21: entry = {14'h0924, 14'h0000};
         8'h22: entry = {14'h0492, 14'h0000};
         8'h23: entry = {14'h0DB6, 14'h0000};
         8'h30: entry = {14'h0000, 14'h0AAA};
         8'h31: entry = {14'h1515, 14'h0000};
         8'h40: entry = {14'h0000, 14'h0000};
         8'h41: entry = {14'h1212, 14'h0000};
         8'h42: entry = {14'h0909, 14'h0000};
         8'h43: entry = {14'h1B1B, 14'h04A4};
         default: entry = '0;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) data <= '0;
      else        data <= entry;
   end

endmodule

// File: rtl/chip_vector_sequencer.sv
// Table-driven functional test of the 14-pin socket: walks the selected part's
// vectors, drives inputs, waits for settle, compares synchronized outputs.
module chip_vector_sequencer
   import chip_checker_pkg::*;
#(
   parameter int SETTLE_CYCLES = 50
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                Start,
   input  logic                Abort,
   input  logic [3:0]          Chip_Sel,
   input  logic [NUM_PINS-1:0] Pin_In,
   output logic [NUM_PINS-1:0] Pin_OE,
   output logic [NUM_PINS-1:0] Pin_Out,
   output logic                Busy,
   output logic                Done,
   output logic                Pass,
   output logic [4:0]          Fail_Index,
   output logic [NUM_PINS-1:0] Err_Pins,
   output logic [2:0]          Dbg_State
);

   localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYCLES - 1);

   state_e              state;
   logic [3:0]          chip;
   logic [IDX_W-1:0]    index;
   logic [9:0]          cnt;
   logic [NUM_PINS-1:0] exp_word;
   logic [NUM_PINS-1:0] sync1, sync2;
   logic [NUM_PINS-1:0] mismatch;
   vec_entry_t          rom_data;

   chip_vector_rom u_rom (
      .Clk   (Clk),
      .Reset (Reset),
      .chip  (chip),
      .index (index),
      .data  (rom_data)
   );

   assign mismatch  = (sync2 ^ exp_word) & out_mask(chip);
   assign Dbg_State = state;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= Pin_In;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         chip       <= '0;
         index      <= '0;
         cnt        <= '0;
         exp_word   <= '0;
         Pin_OE     <= '0;
         Pin_Out    <= '0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         Pass       <= 1'b0;
         Fail_Index <= '0;
         Err_Pins   <= '0;
      end else begin
         Done <= 1'b0;
         if (state != IDLE && Abort) begin
            // Abandon quietly: tristate the socket, keep the result registers.
            state  <= IDLE;
            Pin_OE <= '0;
            Busy   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (Start && !Abort) begin
                     chip       <= Chip_Sel;
                     index      <= '0;
                     Pass       <= 1'b0;
                     Fail_Index <= '0;
                     Err_Pins   <= '0;
                     Busy       <= 1'b1;
                     state      <= LOAD;
                  end
               end
               LOAD: begin
                  if (vec_count(chip) == '0) begin
                     Pass       <= 1'b0;
                     Fail_Index <= 5'h1F;
                     state      <= FINISH;
                  end else begin
                     state <= APPLY;
                  end
               end
               APPLY: begin
                  Pin_Out  <= rom_data.drive;
                  Pin_OE   <= oe_mask(chip) & ~PWR_PINS;
                  exp_word <= rom_data.expected;
                  cnt      <= '0;
                  state    <= SETTLE;
               end
               SETTLE: begin
                  cnt <= cnt + 10'd1;
                  if (cnt == SETTLE_LAST) state <= CHECK;
               end
               CHECK: begin
                  if (|mismatch) begin
                     Fail_Index <= {1'b0, index};
                     Err_Pins   <= mismatch;
                     Pass       <= 1'b0;
                     state      <= FINISH;
                  end else if ({1'b0, index} == vec_count(chip) - 5'd1) begin
                     Pass  <= 1'b1;
                     state <= FINISH;
                  end else begin
                     index <= index + 1'b1;
                     state <= LOAD;
                  end
               end
               FINISH: begin
                  Done   <= 1'b1;
                  Pin_OE <= '0;
                  Busy   <= 1'b0;
                  state  <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_chip_vector_sequencer.sv
// Directed bench: a behavioural 7400/7404 in the socket (with optional stuck
// pins) drives Pin_In; results and Done timing are checked per test.
module tb_chip_vector_sequencer;
   import chip_checker_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [3:0]  chip_sel = 4'd0;
   logic [13:0] pin_in;
   logic [13:0] pin_oe, pin_out, err_pins;
   logic        busy, done, pass;
   logic [4:0]  fail_index;
   logic [2:0]  dbg_state;

   logic        sock_7404 = 1'b0;
   logic        stuck8 = 1'b0;
   logic        stuck3 = 1'b0;
   logic [13:0] d;

   int total = 0;
   int bad = 0;
   int pwr_viol = 0;
   int oe_seen = 0;
   int done_cnt = 0;
   logic [19:0] exp_q[$];

   chip_vector_sequencer #(.SETTLE_CYCLES(4)) dut (
      .Clk        (clk),
      .Reset      (rst_n),
      .Start      (start),
      .Abort      (abort),
      .Chip_Sel   (chip_sel),
      .Pin_In     (pin_in),
      .Pin_OE     (pin_oe),
      .Pin_Out    (pin_out),
      .Busy       (busy),
      .Done       (done),
      .Pass       (pass),
      .Fail_Index (fail_index),
      .Err_Pins   (err_pins),
      .Dbg_State  (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // socket model: driven pins read back, gate outputs computed from them
   always_comb begin
      d = pin_out & pin_oe;
      pin_in = d;
      if (sock_7404) begin
         pin_in[1]  = ~d[0];
         pin_in[3]  = ~d[2];
         pin_in[5]  = ~d[4];
         pin_in[7]  = ~d[8];
         pin_in[9]  = ~d[10];
         pin_in[11] = ~d[12];
      end else begin
         pin_in[2]  = ~(d[0] & d[1]);
         pin_in[5]  = ~(d[3] & d[4]);
         pin_in[7]  = ~(d[8] & d[9]);
         pin_in[10] = ~(d[11] & d[12]);
      end
      if (stuck8) pin_in[7] = 1'b0;
      if (stuck3) pin_in[2] = 1'b1;
   end

   always @(negedge clk) begin
      if (pin_oe[6] || pin_oe[13]) pwr_viol++;
      if (|pin_oe) oe_seen++;
      if (done) done_cnt++;
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_test(input logic [3:0] sel);
      chip_sel = sel;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic run_test(input string tag, input logic [3:0] sel, input int cyc_exp,
                           input logic p, input logic [4:0] fi, input logic [13:0] ep);
      int n;
      exp_q.push_back({p, fi, ep});
      start_test(sel);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      wait_done(n);
      chk({tag, "_cycles"}, 32'(n), 32'(cyc_exp));
      chk({tag, "_result"}, 32'({pass, fail_index, err_pins}), 32'(exp_q.pop_front()));
      tick();
      chk({tag, "_done_pulse"}, 32'({done, busy, pin_oe}), 32'd0);
   endtask

   initial begin
      int n;
      int busy_low;
      int dc;

      tick();
      tick();
      chk("reset_outputs", 32'({pin_oe, pin_out, busy, done}), 32'd0);
      chk("reset_results", 32'({pass, fail_index, err_pins, dbg_state}), 32'd0);
      rst_n = 1'b1;
      tick();

      run_test("good_7400", 4'd1, 29, 1'b1, 5'd0, 14'h0000);
      chk("good_7400_pin_out", 32'(pin_out), 32'h1B1B);

      stuck8 = 1'b1;
      run_test("stuck8", 4'd1, 8, 1'b0, 5'd0, 14'h0080);
      stuck8 = 1'b0;

      stuck3 = 1'b1;
      run_test("stuck3", 4'd1, 29, 1'b0, 5'd3, 14'h0004);
      stuck3 = 1'b0;

      run_test("wrong_part", 4'd4, 8, 1'b0, 5'd0, 14'h04A4);

      sock_7404 = 1'b1;
      run_test("good_7404", 4'd3, 15, 1'b1, 5'd0, 14'h0000);
      sock_7404 = 1'b0;

      oe_seen = 0;
      run_test("unsupported", 4'hF, 2, 1'b0, 5'h1F, 14'h0000);
      chk("unsupported_oe_seen", 32'(oe_seen), 32'd0);

      // abort during SETTLE of vector 2; prior test leaves Pass=0, Fail_Index=0
      stuck8 = 1'b1;
      run_test("pre_abort", 4'd1, 8, 1'b0, 5'd0, 14'h0080);
      stuck8 = 1'b0;
      start_test(4'd1);
      for (int i = 0; i < 17; i++) tick();
      chk("abort_pre_state", 32'({dbg_state, pin_oe, pin_out}), 32'({3'd3, 14'h1B1B, 14'h0909}));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_idle", 32'({dbg_state, pin_oe, busy, done}), 32'd0);
      dc = done_cnt;
      for (int i = 0; i < 40; i++) tick();
      chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
      chk("abort_results", 32'({pass, fail_index}), 32'd0);

      // Start and Abort together in IDLE
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      tick();
      chk("start_abort_idle", 32'({dbg_state, busy}), 32'd0);

      // Start re-pulsed mid-test with a different Chip_Sel
      start_test(4'd1);
      n = 0;
      busy_low = 0;
      while (done !== 1'b1 && n < 200) begin
         if (n == 5) begin
            start = 1'b1;
            chip_sel = 4'hF;
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
         if (done !== 1'b1 && busy !== 1'b1) busy_low++;
      end
      start = 1'b0;
      chk("repulse_cycles", 32'(n), 32'd29);
      chk("repulse_busy", 32'(busy_low), 32'd0);
      chk("repulse_pass", 32'({pass, fail_index, err_pins}), 32'h80000);

      // asynchronous reset while in APPLY
      start_test(4'd1);
      tick();
      chk("apply_state", 32'({dbg_state, busy, pin_out}), 32'({3'd2, 1'b1, 14'h1B1B}));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", 32'({pin_oe, pin_out, busy, done}), 32'd0);
      chk("async_reset_results", 32'({pass, fail_index, err_pins, dbg_state}), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      chk("pwr_pins_never_driven", 32'(pwr_viol), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
